// File: rtl/updown_counter_seq.sv
// Command sequencer for the up/down counter datapath.
// Accepts one GOTO / STEP_UP / STEP_DN / CLEAR command at a time over a
// valid/ready handshake, drives the counter's enable, direction and clear,
// and watches the counter value to decide when the command has finished.
module updown_counter_seq #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          SHORTEST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_arg,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_cnt_en,
    output logic             o_up_down,
    output logic             o_cnt_clr,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    typedef enum logic [1:0] {
        OP_GOTO    = 2'b00,
        OP_STEP_UP = 2'b01,
        OP_STEP_DN = 2'b10,
        OP_CLEAR   = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CLR,
        S_DONE
    } state_e;

    // Half the counter range: a GOTO distance equal to this is a tie and goes up.
    localparam logic [WIDTH-1:0] HALF        = {1'b1, {(WIDTH-1){1'b0}}};
    // GOTO step budget of one full lap of the counter.
    localparam logic [WIDTH:0]   BUDGET_FULL = {1'b1, {WIDTH{1'b0}}};

    state_e           state;
    logic             goto_q;
    logic             dir_q;
    logic             err_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH:0]   budget;

    logic [WIDTH-1:0] diff;
    logic             goto_up;
    logic             at_target;
    logic             cnt_en;

    // Direction decision for a GOTO, evaluated against the live count at accept.
    always_comb begin
        diff      = i_cmd_arg - i_count;
        goto_up   = 1'b0;
        if (SHORTEST) begin
            goto_up = (diff <= HALF);
        end else begin
            goto_up = (i_cmd_arg > i_count);
        end
        at_target = (i_count == target_q);
    end

    // Step enable: GOTO stops combinationally on the first matching count so it never overshoots.
    always_comb begin
        cnt_en = 1'b0;
        if (state == S_RUN && !i_abort) begin
            if (goto_q) begin
                cnt_en = !at_target && (budget != '0);
            end else begin
                cnt_en = (remaining != '0);
            end
        end
    end

    // Command sequencing state machine.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            goto_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            target_q  <= '0;
            remaining <= '0;
            budget    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        err_q     <= 1'b0;
                        target_q  <= i_cmd_arg;
                        remaining <= i_cmd_arg;
                        budget    <= BUDGET_FULL;
                        unique case (cmd_op_e'(i_cmd_op))
                            OP_GOTO: begin
                                goto_q <= 1'b1;
                                dir_q  <= goto_up;
                                state  <= (i_count == i_cmd_arg) ? S_DONE : S_RUN;
                            end
                            OP_STEP_UP: begin
                                goto_q <= 1'b0;
                                dir_q  <= 1'b1;
                                state  <= (i_cmd_arg == '0) ? S_DONE : S_RUN;
                            end
                            OP_STEP_DN: begin
                                goto_q <= 1'b0;
                                dir_q  <= 1'b0;
                                state  <= (i_cmd_arg == '0) ? S_DONE : S_RUN;
                            end
                            OP_CLEAR: begin
                                goto_q <= 1'b0;
                                state  <= S_CLR;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        state <= S_IDLE;
                    end else if (goto_q) begin
                        if (at_target) begin
                            state <= S_DONE;
                        end else if (budget == '0) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            budget <= budget - 1'b1;
                        end
                    end else begin
                        // Leave on the last enabled step so DONE lands right after it.
                        if (remaining != '0) begin
                            remaining <= remaining - 1'b1;
                        end
                        if (remaining <= WIDTH'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_CLR: begin
                    state <= i_abort ? S_IDLE : S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = (state == S_IDLE);
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_cnt_clr   = (state == S_CLR) && !i_abort;
    assign o_cnt_en    = cnt_en;
    assign o_up_down   = dir_q;
    assign o_error     = err_q;

    // Counter enable and clear must never be asserted together.
    assert property (@(posedge i_clk) !(o_cnt_en && o_cnt_clr));

endmodule

// File: tb/tb_updown_counter_seq.sv
// Directed bench for updown_counter_seq with a behavioural counter in the loop.
module tb_updown_counter_seq;

    localparam logic [1:0] GOTO = 2'b00;
    localparam logic [1:0] SUP  = 2'b01;
    localparam logic [1:0] SDN  = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       abort;
    logic [3:0] count;
    logic       cnt_en;
    logic       up_down;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic       error;

    logic       load_en;
    logic [3:0] load_val;
    logic       stall;

    int tests;
    int fails;

    updown_counter_seq #(.WIDTH(4), .SHORTEST(1'b1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_arg   (cmd_arg),
        .i_abort     (abort),
        .i_count     (count),
        .o_cnt_en    (cnt_en),
        .o_up_down   (up_down),
        .o_cnt_clr   (cnt_clr),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: preloadable, can be stalled to emulate a stuck datapath.
    always @(posedge clk) begin
        if (load_en) begin
            count <= load_val;
        end else if (!stall) begin
            if (cnt_clr) begin
                count <= 4'd0;
            end else if (cnt_en) begin
                count <= up_down ? count + 4'd1 : count - 4'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; consumes one cycle.
    task automatic set_count(input logic [3:0] v);
        load_val = v;
        load_en  = 1'b1;
        @(posedge clk); #1;
        load_en  = 1'b0;
    endtask

    // Present a command in cycle t; returns at posedge+1 of cycle t+1.
    task automatic issue(input logic [1:0] op, input logic [3:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        check("ready_at_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 4'd0;
    endtask

    int         ob_en_n, ob_en_first, ob_en_last, ob_clr_n, ob_clr_first, ob_done_k, ob_overlap;
    logic       ob_err, ob_dir;
    logic [3:0] ob_count;

    // Watch cycles t+1.. until done; returns at posedge+1 of the cycle after the post-done cycle.
    task automatic observe(input int max_cycles);
        ob_en_n = 0; ob_en_first = 0; ob_en_last = 0;
        ob_clr_n = 0; ob_clr_first = 0; ob_done_k = -1; ob_overlap = 0;
        ob_err = 1'b0; ob_dir = 1'b0; ob_count = 4'd0;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            if (cnt_en) begin
                ob_en_n++;
                if (ob_en_first == 0) ob_en_first = k;
                ob_en_last = k;
            end
            if (cnt_clr) begin
                ob_clr_n++;
                if (ob_clr_first == 0) ob_clr_first = k;
            end
            if (cnt_en && cnt_clr) ob_overlap++;
            if (done) begin
                ob_done_k = k;
                ob_err    = error;
                ob_dir    = up_down;
                ob_count  = count;
                break;
            end
            @(posedge clk); #1;
        end
        if (ob_done_k < 0) begin
            check("done_timeout", 32'd0, 32'd1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            @(posedge clk); #1;
            @(negedge clk);
            check("ready_after_done", 32'(cmd_ready), 32'd1);
            check("done_one_cycle", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [3:0] start;
        logic [1:0] op;
        logic [3:0] arg;
        int         en_n;
        int         done_k;
        int         clr_n;
        bit         chk_dir;
        logic       dir;
        logic [3:0] fin;
    } vec_t;

    vec_t vecs[13];

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = GOTO; cmd_arg = 4'd3; abort = 1'b0;
        load_en = 1'b1; load_val = 4'd9; stall = 1'b0;

        // Reset held across a valid command.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(cnt_en), 32'd0);
        check("rst_up", 32'(up_down), 32'd0);
        check("rst_clr", 32'(cnt_clr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_count", 32'(count), 32'd9);
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0; load_en = 1'b0;
        @(negedge clk);
        check("no_accept_in_reset", 32'(busy), 32'd0);
        @(posedge clk); #1;

        //          start  op    arg  en  done clr chk dir fin
        vecs[0]  = '{4'd14, SUP,  4'd3,  3,  4, 0, 1, 1'b1, 4'd1};
        vecs[1]  = '{4'd14, GOTO, 4'd2,  4,  6, 0, 1, 1'b1, 4'd2};
        vecs[2]  = '{4'd0,  GOTO, 4'd8,  8, 10, 0, 1, 1'b1, 4'd8};
        vecs[3]  = '{4'd12, GOTO, 4'd3,  7,  9, 0, 1, 1'b1, 4'd3};
        vecs[4]  = '{4'd10, GOTO, 4'd5,  5,  7, 0, 1, 1'b0, 4'd5};
        vecs[5]  = '{4'd0,  GOTO, 4'd15, 1,  3, 0, 1, 1'b0, 4'd15};
        vecs[6]  = '{4'd7,  GOTO, 4'd0,  7,  9, 0, 1, 1'b0, 4'd0};
        vecs[7]  = '{4'd1,  SDN,  4'd2,  2,  3, 0, 1, 1'b0, 4'd15};
        vecs[8]  = '{4'd6,  SUP,  4'd0,  0,  1, 0, 1, 1'b1, 4'd6};
        vecs[9]  = '{4'd6,  SDN,  4'd0,  0,  1, 0, 1, 1'b0, 4'd6};
        vecs[10] = '{4'd6,  GOTO, 4'd6,  0,  1, 0, 1, 1'b1, 4'd6};
        vecs[11] = '{4'd11, CLR,  4'd5,  0,  2, 1, 0, 1'b0, 4'd0};
        vecs[12] = '{4'd0,  SUP,  4'd15, 15, 16, 0, 1, 1'b1, 4'd15};

        foreach (vecs[i]) begin
            set_count(vecs[i].start);
            issue(vecs[i].op, vecs[i].arg);
            observe(40);
            check($sformatf("v%0d_en_n", i), 32'(ob_en_n), 32'(vecs[i].en_n));
            if (vecs[i].en_n > 0) begin
                check($sformatf("v%0d_en_first", i), 32'(ob_en_first), 32'd1);
                check($sformatf("v%0d_en_last", i), 32'(ob_en_last), 32'(vecs[i].en_n));
            end
            check($sformatf("v%0d_done_k", i), 32'(ob_done_k), 32'(vecs[i].done_k));
            check($sformatf("v%0d_error", i), 32'(ob_err), 32'd0);
            check($sformatf("v%0d_clr_n", i), 32'(ob_clr_n), 32'(vecs[i].clr_n));
            if (vecs[i].clr_n > 0)
                check($sformatf("v%0d_clr_first", i), 32'(ob_clr_first), 32'd1);
            check($sformatf("v%0d_overlap", i), 32'(ob_overlap), 32'd0);
            if (vecs[i].chk_dir)
                check($sformatf("v%0d_dir", i), 32'(ob_dir), 32'(vecs[i].dir));
            check($sformatf("v%0d_final", i), 32'(ob_count), 32'(vecs[i].fin));
        end

        // Abort mid STEP_DN: en at t+1,t+2, abort at t+3, idle at t+4 with count 3.
        set_count(4'd5);
        issue(SDN, 4'd6);
        @(negedge clk);
        check("abort_en_t1", 32'(cnt_en), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_en_t2", 32'(cnt_en), 32'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_en_t3", 32'(cnt_en), 32'd0);
        check("abort_busy_t3", 32'(busy), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_ready_t4", 32'(cmd_ready), 32'd1);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_count", 32'(count), 32'd3);
        @(posedge clk); #1;
        issue(SUP, 4'd1);
        observe(10);
        check("post_abort_done", 32'(ob_done_k), 32'd2);
        check("post_abort_count", 32'(ob_count), 32'd4);

        // Abort during CLR: no clear pulse, no done.
        issue(CLR, 4'd0);
        abort = 1'b1;
        @(negedge clk);
        check("abort_clr_low", 32'(cnt_clr), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_clr_idle", 32'(cmd_ready), 32'd1);
        check("abort_clr_no_done", 32'(done), 32'd0);
        check("abort_clr_count", 32'(count), 32'd4);
        @(posedge clk); #1;

        // Abort together with a valid command in IDLE: command still accepted.
        abort = 1'b1;
        issue(SUP, 4'd1);
        abort = 1'b0;
        observe(10);
        check("abort_idle_done", 32'(ob_done_k), 32'd2);
        check("abort_idle_count", 32'(ob_count), 32'd5);

        // Stalled counter: GOTO 7 from 0 burns the 16-step budget and errors.
        set_count(4'd0);
        stall = 1'b1;
        issue(GOTO, 4'd7);
        observe(40);
        stall = 1'b0;
        check("stall_en_n", 32'(ob_en_n), 32'd16);
        check("stall_en_last", 32'(ob_en_last), 32'd16);
        check("stall_done_k", 32'(ob_done_k), 32'd18);
        check("stall_error", 32'(ob_err), 32'd1);
        check("stall_error_held", 32'(error), 32'd1);
        issue(SUP, 4'd0);
        observe(10);
        check("error_cleared", 32'(ob_err), 32'd0);

        // Command presented while busy is dropped, not queued.
        set_count(4'd2);
        issue(SUP, 4'd2);
        cmd_valid = 1'b1; cmd_op = CLR; cmd_arg = 4'd0;
        observe(10);
        cmd_valid = 1'b0;
        check("busy_ignore_done", 32'(ob_done_k), 32'd3);
        check("busy_ignore_clr", 32'(ob_clr_n), 32'd0);
        check("busy_ignore_count", 32'(ob_count), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
